// File: rtl/frog_defs_pkg.sv
// Shared screen geometry and lane FSM encoding for the frog game blocks
// (car lanes, collision checker, sprite renderer).
package frog_defs;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } lane_state_t;

endpackage

// File: rtl/car_lane_driver_if.sv
// Control pulses into one car lane and the registered car position coming out.
interface car_lane_driver_if;
    import frog_defs::*;

    logic              i_Frame_Tick;
    logic              i_Enable;
    logic              i_Restart;
    logic              i_Speed_Up;
    logic [X_W-1:0]    o_Car_X;
    logic [Y_W-1:0]    o_Car_Y;
    logic              o_Car_Valid;
    logic              o_Wrapped;
    lane_state_t       o_State;

    // o_Car_Valid qualifies o_Car_X/o_Car_Y every cycle: consumers treat the
    // car as absent while it is low. No back-pressure exists; pulses are
    // single-cycle and always accepted on the edge that samples them.
    modport master (
        output i_Frame_Tick, i_Enable, i_Restart, i_Speed_Up,
        input  o_Car_X, o_Car_Y, o_Car_Valid, o_Wrapped, o_State
    );

    modport slave (
        input  i_Frame_Tick, i_Enable, i_Restart, i_Speed_Up,
        output o_Car_X, o_Car_Y, o_Car_Valid, o_Wrapped, o_State
    );

endinterface

// File: rtl/car_lane_driver_step_timer.sv
// Counts qualifying frame ticks and strobes o_Step on every PERIOD-th one.
// Also usable for frog hop timing.
module step_timer #(
    parameter int PERIOD = 2
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Enable,
    input  logic i_Clear,
    input  logic i_Tick,
    output logic o_Step
);

    localparam logic [3:0] LAST = 4'(PERIOD - 1);

    logic [3:0] count_q;
    logic       at_last;

    assign at_last = (count_q == LAST);
    assign o_Step  = i_Enable && i_Tick && at_last && !i_Clear;

    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Clear) begin
            count_q <= 4'd0;
        end else if (i_Enable && i_Tick) begin
            count_q <= at_last ? 4'd0 : count_q + 4'd1;
        end
    end

endmodule

// File: rtl/car_lane_driver.sv
// One obstacle car moving along a fixed lane: steps on frame ticks by
// (1 + level) pixels and wraps at the screen edge.
module car_lane_driver
    import frog_defs::*;
#(
    parameter logic [Y_W-1:0] LANE_Y          = 9'd64,
    parameter logic [X_W-1:0] START_X         = 10'd0,
    parameter logic           DIRECTION       = 1'b0,
    parameter int             FRAMES_PER_STEP = 2,
    parameter int             MAX_LEVEL       = 3
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    car_lane_driver_if.slave    bus
);

    localparam logic [10:0] SCREEN_W11 = 11'(SCREEN_W);
    localparam logic [2:0]  LEVEL_MAX  = 3'(MAX_LEVEL);

    lane_state_t    state_q, state_d;
    logic [2:0]     level_q, level_d;
    logic [X_W-1:0] x_q, x_d;
    logic           wrapped_q, wrapped_d;
    logic           valid_q;

    logic           timer_en;
    logic           step_strobe;
    logic [3:0]     step;
    logic [10:0]    sum_r;
    logic [10:0]    sum_l;

    // Restart owns the cycle, so the timer must not also count that tick.
    assign timer_en = (state_q == S_RUN) && bus.i_Enable && !bus.i_Restart;

    step_timer #(
        .PERIOD (FRAMES_PER_STEP)
    ) u_step_timer (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Enable (timer_en),
        .i_Clear  (bus.i_Restart),
        .i_Tick   (bus.i_Frame_Tick),
        .o_Step   (step_strobe)
    );

    assign step  = {1'b0, level_q} + 4'd1;
    assign sum_r = {1'b0, x_q} + {7'd0, step};
    assign sum_l = {1'b0, x_q} + SCREEN_W11 - {7'd0, step};

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        x_d       = x_q;
        wrapped_d = 1'b0;

        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RUN:   if (!bus.i_Enable) state_d = S_PAUSE;
            S_PAUSE: if (bus.i_Enable)  state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && bus.i_Speed_Up && level_q != LEVEL_MAX) begin
            level_d = level_q + 3'd1;
        end

        // The move uses level_q, so a coincident speed-up only affects later steps.
        if (step_strobe) begin
            if (!DIRECTION) begin
                if (sum_r >= SCREEN_W11) begin
                    x_d       = 10'(sum_r - SCREEN_W11);
                    wrapped_d = 1'b1;
                end else begin
                    x_d = sum_r[X_W-1:0];
                end
            end else begin
                if (x_q < {6'd0, step}) begin
                    x_d       = sum_l[X_W-1:0];
                    wrapped_d = 1'b1;
                end else begin
                    x_d = x_q - {6'd0, step};
                end
            end
        end

        if (bus.i_Restart) begin
            state_d   = S_RUN;
            level_d   = 3'd0;
            x_d       = START_X;
            wrapped_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            level_q   <= 3'd0;
            x_q       <= START_X;
            wrapped_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            x_q       <= x_d;
            wrapped_q <= wrapped_d;
            valid_q   <= (state_d != S_IDLE);
        end
    end

    assign bus.o_Car_X     = x_q;
    assign bus.o_Car_Y     = LANE_Y;
    assign bus.o_Car_Valid = valid_q;
    assign bus.o_Wrapped   = wrapped_q;
    assign bus.o_State     = state_q;

endmodule

// File: tb/tb_car_lane_driver.sv
// Directed-vector bench for car_lane_driver: three lanes with different
// start/direction/period exercise stepping, wrap, pause, restart and reset.
module tb_car_lane_driver;
    import frog_defs::*;

    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    car_lane_driver_if ia ();
    car_lane_driver_if ib ();
    car_lane_driver_if ic ();

    car_lane_driver #(
        .LANE_Y (9'd64), .START_X (10'd100), .DIRECTION (1'b0),
        .FRAMES_PER_STEP (2), .MAX_LEVEL (3)
    ) u_a (.i_Clk (clk), .i_Reset (rst), .bus (ia));

    car_lane_driver #(
        .LANE_Y (9'd96), .START_X (10'd638), .DIRECTION (1'b0),
        .FRAMES_PER_STEP (1), .MAX_LEVEL (3)
    ) u_b (.i_Clk (clk), .i_Reset (rst), .bus (ib));

    car_lane_driver #(
        .LANE_Y (9'd128), .START_X (10'd1), .DIRECTION (1'b1),
        .FRAMES_PER_STEP (1), .MAX_LEVEL (3)
    ) u_c (.i_Clk (clk), .i_Reset (rst), .bus (ic));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then drop every single-cycle pulse.
    task automatic step_clk();
        @(posedge clk);
        #1;
        ia.i_Frame_Tick = 1'b0; ia.i_Restart = 1'b0; ia.i_Speed_Up = 1'b0;
        ib.i_Frame_Tick = 1'b0; ib.i_Restart = 1'b0; ib.i_Speed_Up = 1'b0;
        ic.i_Frame_Tick = 1'b0; ic.i_Restart = 1'b0; ic.i_Speed_Up = 1'b0;
    endtask

    task automatic tick_a(input int n);
        for (int i = 0; i < n; i++) begin
            ia.i_Frame_Tick = 1'b1;
            step_clk();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        ia.i_Enable = 1'b1; ib.i_Enable = 1'b1; ic.i_Enable = 1'b1;
        ia.i_Frame_Tick = 1'b0; ia.i_Restart = 1'b0; ia.i_Speed_Up = 1'b0;
        ib.i_Frame_Tick = 1'b0; ib.i_Restart = 1'b0; ib.i_Speed_Up = 1'b0;
        ic.i_Frame_Tick = 1'b0; ic.i_Restart = 1'b0; ic.i_Speed_Up = 1'b0;
        step_clk();
        check("rst_y_during_reset", 32'(ia.o_Car_Y), 32'd64);
        step_clk();
        rst = 1'b0;

        check("rst_x",       32'(ia.o_Car_X), 32'd100);
        check("rst_valid",   32'(ia.o_Car_Valid), 32'd0);
        check("rst_wrapped", 32'(ia.o_Wrapped), 32'd0);
        check("rst_state",   32'(ia.o_State), 32'(S_IDLE));
        check("rst_y_b",     32'(ib.o_Car_Y), 32'd96);

        tick_a(1);
        check("idle_hold_x", 32'(ia.o_Car_X), 32'd100);

        // Lane A: restart then six ticks at period 2, step 1
        ia.i_Restart = 1'b1;
        step_clk();
        check("restart_x",     32'(ia.o_Car_X), 32'd100);
        check("restart_valid", 32'(ia.o_Car_Valid), 32'd1);
        check("restart_state", 32'(ia.o_State), 32'(S_RUN));
        tick_a(1); check("run_t1", 32'(ia.o_Car_X), 32'd100);
        tick_a(1); check("run_t2", 32'(ia.o_Car_X), 32'd101);
        tick_a(1); check("run_t3", 32'(ia.o_Car_X), 32'd101);
        tick_a(1); check("run_t4", 32'(ia.o_Car_X), 32'd102);
        tick_a(2); check("run_t6", 32'(ia.o_Car_X), 32'd103);
        check("run_no_wrap", 32'(ia.o_Wrapped), 32'd0);

        // Half a period, then pause for 10 ticks with one speed-up inside
        tick_a(1);
        check("pre_pause_x", 32'(ia.o_Car_X), 32'd103);
        ia.i_Enable = 1'b0;
        step_clk();
        check("pause_state", 32'(ia.o_State), 32'(S_PAUSE));
        check("pause_valid", 32'(ia.o_Car_Valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            ia.i_Frame_Tick = 1'b1;
            if (i == 4) ia.i_Speed_Up = 1'b1;
            step_clk();
        end
        check("pause_hold_x", 32'(ia.o_Car_X), 32'd103);
        ia.i_Enable = 1'b1;
        step_clk();
        check("resume_state", 32'(ia.o_State), 32'(S_RUN));
        tick_a(1);
        check("resume_first_step", 32'(ia.o_Car_X), 32'd105);

        // Level 2, then restart coinciding with speed-up and tick
        ia.i_Speed_Up = 1'b1;
        step_clk();
        tick_a(2);
        check("level2_step", 32'(ia.o_Car_X), 32'd108);
        ia.i_Restart = 1'b1; ia.i_Speed_Up = 1'b1; ia.i_Frame_Tick = 1'b1;
        step_clk();
        check("coinc_restart_x",  32'(ia.o_Car_X), 32'd100);
        check("coinc_no_wrap",    32'(ia.o_Wrapped), 32'd0);
        tick_a(2);
        check("coinc_level0", 32'(ia.o_Car_X), 32'd101);

        // Reset mid-run returns to idle and stays put
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        check("midrst_x",     32'(ia.o_Car_X), 32'd100);
        check("midrst_valid", 32'(ia.o_Car_Valid), 32'd0);
        check("midrst_state", 32'(ia.o_State), 32'(S_IDLE));
        check("midrst_y",     32'(ia.o_Car_Y), 32'd64);
        tick_a(3);
        check("midrst_idle_x", 32'(ia.o_Car_X), 32'd100);

        // Lane B: right wrap at level 3, then saturation
        ib.i_Restart = 1'b1;
        step_clk();
        check("b_restart_x", 32'(ib.o_Car_X), 32'd638);
        for (int i = 0; i < 3; i++) begin
            ib.i_Speed_Up = 1'b1;
            step_clk();
        end
        ib.i_Frame_Tick = 1'b1;
        step_clk();
        check("b_wrap_x",     32'(ib.o_Car_X), 32'd2);
        check("b_wrap_pulse", 32'(ib.o_Wrapped), 32'd1);
        step_clk();
        check("b_wrap_one_cycle", 32'(ib.o_Wrapped), 32'd0);
        check("b_hold_x",         32'(ib.o_Car_X), 32'd2);
        for (int i = 0; i < 5; i++) begin
            ib.i_Speed_Up = 1'b1;
            step_clk();
        end
        ib.i_Frame_Tick = 1'b1;
        step_clk();
        check("b_sat_x",       32'(ib.o_Car_X), 32'd6);
        check("b_sat_no_wrap", 32'(ib.o_Wrapped), 32'd0);

        // Lane C: left wrap at level 1
        ic.i_Restart = 1'b1;
        step_clk();
        check("c_restart_x", 32'(ic.o_Car_X), 32'd1);
        ic.i_Speed_Up = 1'b1;
        step_clk();
        ic.i_Frame_Tick = 1'b1;
        step_clk();
        check("c_wrap_x",     32'(ic.o_Car_X), 32'd639);
        check("c_wrap_pulse", 32'(ic.o_Wrapped), 32'd1);
        ic.i_Frame_Tick = 1'b1;
        step_clk();
        check("c_next_x",     32'(ic.o_Car_X), 32'd637);
        check("c_next_nowrap", 32'(ic.o_Wrapped), 32'd0);
        check("c_y",          32'(ic.o_Car_Y), 32'd128);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
